// File: rtl/clock_monitor.sv
// Measures period and high time of a slow clock in the Clock_100M domain.
// Raises Lock after LOCK_CNT in-tolerance periods; Fault is sticky on bad/missing clock.
module clock_monitor #(
  parameter int EXP_PERIOD = 100,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 8
) (
  input  logic             Clock_100M,
  input  logic             Reset_n,
  input  logic             Clk_In,
  input  logic             Enable,
  input  logic             Clear,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] High_Time,
  output logic             Meas_Valid,
  output logic             Lock,
  output logic             Fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             lock_q, lock_d;
  logic             fault_q, fault_d;

  logic             rise, is_good, fault_set;
  logic [CNT_W-1:0] per_inc, hi_inc;
  logic [3:0]       good_inc;
  int               per_diff;

  assign rise     = s2_q & ~s3_q;
  assign per_inc  = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_ONE;
  assign hi_inc   = (hi_cnt_q == CNT_MAX) ? CNT_MAX : hi_cnt_q + CNT_ONE;
  assign good_inc = (good_cnt_q >= LOCK_N) ? LOCK_N : good_cnt_q + 4'd1;
  assign per_diff = int'(per_cnt_q) - EXP_PERIOD;
  assign is_good  = (per_diff <= TOL) && (per_diff >= -TOL);

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    good_cnt_d = good_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    mv_d       = 1'b0;
    lock_d     = lock_q;
    fault_set  = 1'b0;

    case (state_q)
      IDLE: begin
        per_cnt_d  = '0;
        hi_cnt_d   = '0;
        good_cnt_d = '0;
        lock_d     = 1'b0;
        if (Enable) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          state_d   = MEASURE;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d  = per_cnt_q;
          high_d    = hi_cnt_q;
          mv_d      = 1'b1;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
          if (is_good) begin
            good_cnt_d = good_inc;
            lock_d     = lock_q | (good_inc == LOCK_N);
          end else begin
            good_cnt_d = '0;
            lock_d     = 1'b0;
            fault_set  = 1'b1;
          end
        end else begin
          per_cnt_d = per_inc;
          if (s2_q) hi_cnt_d = hi_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stall: only the step onto the saturation value fires, so a parked counter stays quiet
    if (state_q != IDLE && !rise && per_cnt_q == CNT_MAX - CNT_ONE) begin
      fault_set  = 1'b1;
      lock_d     = 1'b0;
      good_cnt_d = '0;
      state_d    = ARM;
    end

    if (!Enable) begin
      state_d    = IDLE;
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
      good_cnt_d = '0;
      lock_d     = 1'b0;
      mv_d       = 1'b0;
      fault_set  = 1'b0;
    end

    fault_d = fault_set | (fault_q & ~Clear);
  end

  always_ff @(posedge Clock_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      {s3_q, s2_q, s1_q} <= 3'b000;
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      mv_q       <= 1'b0;
      lock_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      {s3_q, s2_q, s1_q} <= {s2_q, s1_q, Clk_In};
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      mv_q       <= mv_d;
      lock_q     <= lock_d;
      fault_q    <= fault_d;
    end
  end

  assign Period     = period_q;
  assign High_Time  = high_q;
  assign Meas_Valid = mv_q;
  assign Lock       = lock_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench: stimulus pushes expected measurements, monitors pop on Meas_Valid.
// Two instances: default (100-cycle) and EXP_PERIOD=50.
module tb_clock_monitor;

  logic       Clock_100M, Reset_n, Clear;
  logic       Clk_In, Enable, Clk_In2, Enable2;
  logic [7:0] Period, High_Time, Period2, High_Time2;
  logic       Meas_Valid, Lock, Fault, Meas_Valid2, Lock2, Fault2;

  typedef struct {
    logic [7:0] per;
    logic [7:0] hi;
    logic       lock;
    logic       fault;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  clock_monitor dut (
    .Clock_100M(Clock_100M), .Reset_n(Reset_n), .Clk_In(Clk_In), .Enable(Enable),
    .Clear(Clear), .Period(Period), .High_Time(High_Time), .Meas_Valid(Meas_Valid),
    .Lock(Lock), .Fault(Fault)
  );

  clock_monitor #(.EXP_PERIOD(50)) dut50 (
    .Clock_100M(Clock_100M), .Reset_n(Reset_n), .Clk_In(Clk_In2), .Enable(Enable2),
    .Clear(Clear), .Period(Period2), .High_Time(High_Time2), .Meas_Valid(Meas_Valid2),
    .Lock(Lock2), .Fault(Fault2)
  );

  initial Clock_100M = 1'b0;
  always #5 Clock_100M = ~Clock_100M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input int per, input int hi, input bit lock, input bit fault);
    exp_t e;
    e.per = 8'(per); e.hi = 8'(hi); e.lock = lock; e.fault = fault;
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // One input-clock cycle: rise, hi cycles high, lo cycles low. clr holds Clear
  // across the first three sampling edges, which covers the detection edge.
  task automatic cyc(input int ch, input int hi, input int lo, input bit clr);
    if (ch == 0) Clk_In = 1'b1; else Clk_In2 = 1'b1;
    Clear = clr;
    repeat (3) @(posedge Clock_100M);
    #1 Clear = 1'b0;
    repeat (hi - 3) @(posedge Clock_100M);
    #1;
    if (ch == 0) Clk_In = 1'b0; else Clk_In2 = 1'b0;
    repeat (lo) @(posedge Clock_100M);
    #1;
  endtask

  task automatic clear_pulse();
    Clear = 1'b1;
    @(posedge Clock_100M); #1;
    Clear = 1'b0;
    @(posedge Clock_100M); #1;
  endtask

  always @(negedge Clock_100M) begin
    if (Reset_n && Meas_Valid) begin
      if (q0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_meas_valid: Period %0d with no expected measurement at %0t", Period, $time);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("period",    32'(Period),    32'(e.per));
        chk("high_time", 32'(High_Time), 32'(e.hi));
        chk("lock",      32'(Lock),      32'(e.lock));
        chk("fault",     32'(Fault),     32'(e.fault));
      end
    end
    if (Reset_n && Meas_Valid2) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_meas_valid50: Period %0d with no expected measurement at %0t", Period2, $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("period50",    32'(Period2),    32'(e.per));
        chk("high_time50", 32'(High_Time2), 32'(e.hi));
        chk("lock50",      32'(Lock2),      32'(e.lock));
        chk("fault50",     32'(Fault2),     32'(e.fault));
      end
    end
  end

  initial begin
    int n;
    Reset_n = 1'b0; Clear = 1'b0;
    Clk_In = 1'b0; Enable = 1'b0; Clk_In2 = 1'b0; Enable2 = 1'b0;
    repeat (3) @(posedge Clock_100M);
    #1;
    chk("rst_period",     32'(Period),     0);
    chk("rst_high_time",  32'(High_Time),  0);
    chk("rst_meas_valid", 32'(Meas_Valid), 0);
    chk("rst_lock",       32'(Lock),       0);
    chk("rst_fault",      32'(Fault),      0);
    Reset_n = 1'b1;
    @(posedge Clock_100M); #1;

    // EXP_PERIOD = 50 instance, 25/25 clock
    Enable2 = 1'b1;
    repeat (5) @(posedge Clock_100M); #1;
    cyc(1, 25, 25, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      push(1, 50, 25, i == 4, 1'b0);
      cyc(1, 25, 25, 1'b0);
    end
    Enable2 = 1'b0;

    // Nominal 100-cycle clock; first rise only arms
    Enable = 1'b1;
    repeat (10) @(posedge Clock_100M); #1;
    cyc(0, 50, 50, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      push(0, 100, 50, i == 4, 1'b0);
      cyc(0, 50, 50, 1'b0);
    end

    // 97-cycle period breaks lock; Clear; relock; 98 keeps lock
    push(0, 100, 50, 1'b1, 1'b0); cyc(0, 50, 47, 1'b0);
    push(0, 97, 50, 1'b0, 1'b1);  cyc(0, 50, 48, 1'b0);
    clear_pulse();
    chk("fault_cleared", 32'(Fault), 0);
    for (int i = 1; i <= 4; i++) begin
      push(0, 100, 50, i == 4, 1'b0);
      cyc(0, 50, (i == 4) ? 48 : 50, 1'b0);
    end
    push(0, 98, 50, 1'b1, 1'b0); cyc(0, 50, 45, 1'b0);

    // Bad period detected while Clear is high: set wins
    push(0, 95, 50, 1'b0, 1'b1); cyc(0, 50, 48, 1'b1);
    chk("fault_set_dominant", 32'(Fault), 1);
    clear_pulse();
    for (int i = 1; i <= 4; i++) begin
      push(0, 100, 50, i == 4, 1'b0);
      cyc(0, 50, 50, 1'b0);
    end

    // Clock stops low: per_cnt reaches 255 157 edges after the last cycle ends
    n = 0;
    while (!Fault && n < 400) begin
      @(posedge Clock_100M); #1;
      n++;
    end
    chk("timeout_edges", n, 157);
    chk("timeout_fault", 32'(Fault), 1);
    chk("timeout_lock",  32'(Lock),  0);
    clear_pulse();
    cyc(0, 50, 50, 1'b0);
    push(0, 100, 50, 1'b0, 1'b0); cyc(0, 50, 47, 1'b0);
    push(0, 97, 50, 1'b0, 1'b1);
    Clk_In = 1'b1;
    repeat (10) @(posedge Clock_100M); #1;
    chk("pre_reset_period", 32'(Period), 97);

    // Asynchronous reset mid-period
    Reset_n = 1'b0;
    #2;
    chk("mid_rst_period",     32'(Period),     0);
    chk("mid_rst_high_time",  32'(High_Time),  0);
    chk("mid_rst_meas_valid", 32'(Meas_Valid), 0);
    chk("mid_rst_lock",       32'(Lock),       0);
    chk("mid_rst_fault",      32'(Fault),      0);
    #3 Reset_n = 1'b1;
    Clk_In = 1'b0;
    repeat (5) @(posedge Clock_100M); #1;

    // Lock with Fault set, then drop Enable mid-period
    cyc(0, 50, 50, 1'b0);
    push(0, 100, 50, 1'b0, 1'b0); cyc(0, 50, 45, 1'b0);
    push(0, 95, 50, 1'b0, 1'b1);  cyc(0, 50, 50, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      push(0, 100, 50, 1'b0, 1'b1);
      cyc(0, 50, 50, 1'b0);
    end
    push(0, 100, 50, 1'b1, 1'b1);
    Clk_In = 1'b1;
    repeat (20) @(posedge Clock_100M); #1;
    chk("pre_disable_lock", 32'(Lock), 1);
    Enable = 1'b0;
    @(posedge Clock_100M); #1;
    chk("disable_lock",   32'(Lock),   0);
    chk("disable_period", 32'(Period), 100);
    chk("disable_fault",  32'(Fault),  1);
    Clk_In = 1'b0;
    repeat (50) @(posedge Clock_100M); #1;
    cyc(0, 50, 50, 1'b0);
    cyc(0, 50, 50, 1'b0);
    chk("idle_period_hold", 32'(Period),    100);
    chk("idle_high_hold",   32'(High_Time), 50);
    chk("idle_fault_hold",  32'(Fault),     1);

    repeat (5) @(posedge Clock_100M); #1;
    chk("queue_drained",   q0.size(), 0);
    chk("queue50_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
